// File: rtl/lfsr_checker.sv
// Receive-side checker for the 4-bit LFSR generator stream.
// Hunts for a non-zero seed, verifies LOCK_COUNT predictions, then counts mismatches while locked.
module lfsr_checker #(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned TAP_A        = 3,
   parameter int unsigned TAP_B        = 2,
   parameter int unsigned LOCK_COUNT   = 4,
   parameter int unsigned UNLOCK_COUNT = 3,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             error,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int unsigned MISS_W  = $clog2(UNLOCK_COUNT + 1);

   if (WIDTH != 4) begin : g_width_check
      $error("lfsr_checker supports only WIDTH == 4");
   end

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   state_e             state_q,     state_d;
   logic [WIDTH-1:0]   expected_q,  expected_d;
   logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
   logic [MISS_W-1:0]  miss_cnt_q,  miss_cnt_d;
   logic               locked_q,    locked_d;
   logic               error_q,     error_d;
   logic [CNT_W-1:0]   err_count_q, err_count_d;
   logic [CNT_W-1:0]   cnt_base;
   logic               count_err;

   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
      return {x[WIDTH-2:0], x[TAP_A] ^ x[TAP_B]};
   endfunction

   // Sequence tracking; nothing but error and the counter clear moves without data_valid.
   always_comb begin
      state_d     = state_q;
      expected_d  = expected_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      locked_d    = locked_q;
      error_d     = 1'b0;
      count_err   = 1'b0;

      if (data_valid) begin
         case (state_q)
            ST_HUNT: begin
               if (data_in != '0) begin
                  expected_d  = lfsr_next(data_in);
                  match_cnt_d = '0;
                  state_d     = ST_VERIFY;
               end
            end
            ST_VERIFY: begin
               if (data_in == expected_q) begin
                  expected_d  = lfsr_next(data_in);
                  match_cnt_d = match_cnt_q + MATCH_W'(1);
                  if (match_cnt_d == MATCH_W'(LOCK_COUNT)) begin
                     state_d    = ST_LOCKED;
                     miss_cnt_d = '0;
                     locked_d   = 1'b1;
                  end
               end else if (data_in == '0) begin
                  match_cnt_d = '0;
                  state_d     = ST_HUNT;
               end else begin
                  expected_d  = lfsr_next(data_in);
                  match_cnt_d = '0;
               end
            end
            ST_LOCKED: begin
               // Free-running prediction so one bad word costs exactly one error.
               expected_d = lfsr_next(expected_q);
               if (data_in == expected_q) begin
                  miss_cnt_d = '0;
               end else begin
                  error_d    = 1'b1;
                  count_err  = 1'b1;
                  miss_cnt_d = miss_cnt_q + MISS_W'(1);
                  if (miss_cnt_d == MISS_W'(UNLOCK_COUNT)) begin
                     state_d     = ST_HUNT;
                     match_cnt_d = '0;
                     locked_d    = 1'b0;
                  end
               end
            end
            default: begin
               state_d  = ST_HUNT;
               locked_d = 1'b0;
            end
         endcase
      end

      // Clear first, then a same-cycle counted error increments from zero.
      cnt_base    = clear_cnt ? '0 : err_count_q;
      err_count_d = (count_err && (cnt_base != '1)) ? cnt_base + CNT_W'(1) : cnt_base;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_HUNT;
         expected_q  <= '0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         locked_q    <= 1'b0;
         error_q     <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         expected_q  <= expected_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         locked_q    <= locked_d;
         error_q     <= error_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = locked_q;
   assign error     = error_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboarded bench for lfsr_checker: directed scenarios plus random traffic against a table-driven model.
module tb_lfsr_checker;

   localparam int LOCK_N   = 4;
   localparam int UNLOCK_N = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        data_valid;
   logic        clear_cnt;
   logic [3:0]  data_in;
   logic        locked,  error;
   logic [15:0] err_count;
   logic        locked4, error4;
   logic [3:0]  err_count4;

   always #5 clk = ~clk;

   lfsr_checker dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .clear_cnt(clear_cnt), .locked(locked), .error(error), .err_count(err_count)
   );

   lfsr_checker #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .clear_cnt(clear_cnt), .locked(locked4), .error(error4), .err_count(err_count4)
   );

   typedef struct packed {
      logic        locked;
      logic        error;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // The generator's period-15 sequence starting from 1111.
   logic [3:0] seq [15];
   int         p;

   // Model state: 0 = hunting, 1 = verifying, 2 = locked.
   int         m_mode;
   logic [3:0] m_exp;
   int         m_match, m_miss, m_cnt, m_cnt4;
   bit         m_err;

   function automatic logic [3:0] succ(input logic [3:0] x);
      for (int i = 0; i < 15; i++)
         if (seq[i] == x) return seq[(i + 1) % 15];
      return 4'h0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit v, input logic [3:0] d, input bit clr);
      bit counted;
      counted = 1'b0;
      if (rst) begin
         m_mode = 0; m_exp = 4'h0; m_match = 0; m_miss = 0;
         m_err = 1'b0; m_cnt = 0; m_cnt4 = 0;
         return;
      end
      m_err = 1'b0;
      if (v) begin
         if (m_mode == 0) begin
            if (d != 4'h0) begin m_exp = succ(d); m_match = 0; m_mode = 1; end
         end else if (m_mode == 1) begin
            if (d == m_exp) begin
               m_match++;
               m_exp = succ(d);
               if (m_match == LOCK_N) begin m_mode = 2; m_miss = 0; end
            end else if (d == 4'h0) begin
               m_mode = 0; m_match = 0;
            end else begin
               m_exp = succ(d); m_match = 0;
            end
         end else begin
            if (d == m_exp) m_miss = 0;
            else begin
               counted = 1'b1; m_err = 1'b1; m_miss++;
               if (m_miss == UNLOCK_N) begin m_mode = 0; m_match = 0; end
            end
            m_exp = succ(m_exp);
         end
      end
      if (clr) begin m_cnt = 0; m_cnt4 = 0; end
      if (counted) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt4 < 15) m_cnt4++;
      end
   endtask

   task automatic step(input bit rst, input bit v, input logic [3:0] d, input bit clr);
      exp_t e;
      reset      = ~rst;
      data_valid = v;
      data_in    = d;
      clear_cnt  = clr;
      @(posedge clk);
      model_step(rst, v, d, clr);
      e.locked = (m_mode == 2);
      e.error  = m_err;
      e.cnt    = 16'(m_cnt);
      e.cnt4   = 4'(m_cnt4);
      sb_q.push_back(e);
      #1;
   endtask

   // kind: 0 correct word, 1 corrupted word, 2 lockup word, 3 idle cycle
   task automatic feed(input int kind, input bit clr);
      logic [3:0] mask;
      mask = 4'($urandom_range(1, 15));
      case (kind)
         0: begin step(1'b0, 1'b1, seq[p], clr); p = (p + 1) % 15; end
         1: begin step(1'b0, 1'b1, seq[p] ^ mask, clr); p = (p + 1) % 15; end
         2: step(1'b0, 1'b1, 4'h0, clr);
         default: step(1'b0, 1'b0, 4'($urandom), clr);
      endcase
   endtask

   // Monitor: outputs are presented every cycle, so each push pairs with the next falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("locked",     32'(locked),     32'(e.locked));
         chk("error",      32'(error),      32'(e.error));
         chk("err_count",  32'(err_count),  32'(e.cnt));
         chk("err_count4", 32'(err_count4), 32'(e.cnt4));
         chk("locked4",    32'(locked4),    32'(e.locked));
      end
   end

   initial begin
      seq = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
              4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};
      m_mode = 0; m_exp = 4'h0; m_match = 0; m_miss = 0; m_err = 1'b0; m_cnt = 0; m_cnt4 = 0;
      p = 0;

      // Clean lock over 60 words, including the 0111 -> 1111 wrap
      step(1'b1, 1'b0, 4'h0, 1'b0);
      step(1'b1, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 60; i++) feed(0, 1'b0);

      // Single corrupted word: 1001 replaced by 1011
      while (seq[p] != 4'h9) feed(0, 1'b0);
      step(1'b0, 1'b1, 4'hB, 1'b0);
      p = (p + 1) % 15;
      for (int i = 0; i < 10; i++) feed(0, 1'b0);

      // Valid gap while locked
      for (int i = 0; i < 5; i++) feed(3, 1'b0);
      for (int i = 0; i < 5; i++) feed(0, 1'b0);

      // Loss of lock, lockup words in HUNT, then re-acquisition
      for (int i = 0; i < 3; i++) feed(1, 1'b0);
      for (int i = 0; i < 6; i++) feed(2, 1'b0);
      for (int i = 0; i < 12; i++) feed(0, 1'b0);

      // Saturation: two misses then a match keeps the lock while errors pile up
      for (int i = 0; i < 12; i++) begin
         feed(1, 1'b0);
         feed(1, 1'b0);
         feed(0, 1'b0);
      end
      feed(3, 1'b1);
      feed(3, 1'b0);
      feed(1, 1'b1);
      feed(0, 1'b0);
      feed(1, 1'b0);
      for (int i = 0; i < 4; i++) feed(0, 1'b0);

      // Reset mid-lock, then re-acquire from the start of the sequence
      step(1'b1, 1'b1, seq[p], 1'b0);
      p = 0;
      for (int i = 0; i < 20; i++) feed(0, 1'b0);
      feed(1, 1'b0);
      for (int i = 0; i < 3; i++) feed(0, 1'b0);
      feed(1, 1'b0);
      for (int i = 0; i < 3; i++) feed(0, 1'b0);
      step(1'b1, 1'b1, seq[p], 1'b0);
      p = 0;
      for (int i = 0; i < 12; i++) feed(0, 1'b0);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         int r;
         bit clr;
         r   = $urandom_range(0, 99);
         clr = ($urandom_range(0, 31) == 0);
         if (r < 1) begin
            step(1'b1, 1'b1, seq[p], clr);
            p = $urandom_range(0, 14);
         end else if (r < 15) feed(3, clr);
         else if (r < 24) feed(1, clr);
         else if (r < 27) feed(2, clr);
         else feed(0, clr);
      end

      step(1'b0, 1'b0, 4'h0, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
